alarm_bank: RTL and testbench

//  N-channel alarm bank for the digital clock; successor to the single-alarm block.

---
 rtl/alarm_bank_pkg.sv | 32 +++
 rtl/alarm_bank_channel.sv | 91 +++++++++
 rtl/alarm_bank.sv | 80 ++++++++
 tb/tb_alarm_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_bank_pkg.sv
// rtl/alarm_bank_pkg.sv - shared time widths, channel state encoding and minute arithmetic
package alarm_bank_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int TIME_W   = 11;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } ch_state_t;

  // add_min must be <= MAX_MIN so at most one carry into the hour field
  function automatic logic [TIME_W-1:0] time_add_min(input logic [TIME_W-1:0] t,
                                                     input int unsigned add_min);
    logic [TIME_W-1:0] min_sum;
    logic [TIME_W-1:0] hour_sum;
    min_sum  = TIME_W'(t[MIN_W-1:0]) + TIME_W'(add_min);
    hour_sum = TIME_W'(t[TIME_W-1:MIN_W]);
    if (min_sum > TIME_W'(MAX_MIN)) begin
      min_sum  = min_sum - TIME_W'(MAX_MIN + 1);
      hour_sum = hour_sum + TIME_W'(1);
    end
    if (hour_sum > TIME_W'(MAX_HOUR))
      hour_sum = hour_sum - TIME_W'(MAX_HOUR + 1);
    return {hour_sum[HOUR_W-1:0], min_sum[MIN_W-1:0]};
  endfunction

endpackage

// File: rtl/alarm_bank_channel.sv
// rtl/alarm_bank_channel.sv - one alarm channel: alarm time, snooze target, timeout counter, FSM
module alarm_bank_channel
  import alarm_bank_pkg::*;
#(
  parameter int SNOOZE_MIN  = 5,
  parameter int TIMEOUT_MIN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tick,
  input  logic [TIME_W-1:0] time_in,
  input  logic              set_load,
  input  logic [TIME_W-1:0] time_set_in,
  input  logic              snooze,
  input  logic              end_ring,
  output logic              ringing
);

  localparam int TMO_W = $clog2(TIMEOUT_MIN + 1);

  ch_state_t         state, state_nxt;
  logic [TIME_W-1:0] alarm;
  logic [TIME_W-1:0] snz_target;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
  logic              snz_arm;

  // The alarm register loads independently of enable so a channel can be set before it is armed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      alarm      <= '0;
      snz_target <= '0;
      tmo_cnt    <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      if (set_load)
        alarm <= time_set_in;
      if (snz_arm)
        snz_target <= time_add_min(time_in, SNOOZE_MIN);
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    snz_arm   = 1'b0;
    if (!en || set_load || end_ring) begin
      state_nxt = ST_IDLE;
      tmo_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && time_in == alarm) begin
            state_nxt = ST_RINGING;
            tmo_nxt   = '0;
          end
        end
        ST_RINGING: begin
          if (snooze) begin
            state_nxt = ST_SNOOZED;
            snz_arm   = 1'b1;
          end else if (tick) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_MIN - 1)) begin
              state_nxt = ST_IDLE;
              tmo_nxt   = '0;
            end else begin
              tmo_nxt = tmo_cnt + TMO_W'(1);
            end
          end
        end
        ST_SNOOZED: begin
          if (tick && time_in == snz_target) begin
            state_nxt = ST_RINGING;
            tmo_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          tmo_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ringing = (state == ST_RINGING);
  end

endmodule

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - N-channel alarm bank with minute tick detect, set validation and ring source
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int N_ALARMS    = 4,
  parameter int SNOOZE_MIN  = 5,
  parameter int TIMEOUT_MIN = 10,
  localparam int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TIME_W-1:0]   time_in,
  input  logic [TIME_W-1:0]   time_set_in,
  input  logic [IDX_W-1:0]    set_idx,
  input  logic                set_time,
  input  logic [N_ALARMS-1:0] en_in,
  input  logic                snooze,
  input  logic                end_ring,
  output logic                ring,
  output logic [N_ALARMS-1:0] ring_vec,
  output logic [IDX_W-1:0]    ring_src,
  output logic                set_err
);

  logic [TIME_W-1:0]   prev_time;
  logic                tick;
  logic                time_ok;
  logic                idx_ok;
  logic [N_ALARMS-1:0] set_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_time <= '0;
      set_err   <= 1'b0;
    end else begin
      prev_time <= time_in;
      set_err   <= set_time && !(time_ok && idx_ok);
    end
  end

  // Any change of the time bus counts as a minute tick, including jumps
  assign tick    = (time_in != prev_time);
  assign time_ok = (time_set_in[TIME_W-1:MIN_W] <= HOUR_W'(MAX_HOUR)) &&
                   (time_set_in[MIN_W-1:0] <= MIN_W'(MAX_MIN));
  assign idx_ok  = (32'(set_idx) < N_ALARMS);

  always_comb begin
    set_load = '0;
    for (int i = 0; i < N_ALARMS; i++)
      set_load[i] = set_time && time_ok && idx_ok && (32'(set_idx) == i);
  end

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_ch
    alarm_bank_channel #(
      .SNOOZE_MIN  (SNOOZE_MIN),
      .TIMEOUT_MIN (TIMEOUT_MIN)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en          (en_in[g]),
      .tick        (tick),
      .time_in     (time_in),
      .set_load    (set_load[g]),
      .time_set_in (time_set_in),
      .snooze      (snooze),
      .end_ring    (end_ring),
      .ringing     (ring_vec[g])
    );
  end

  assign ring = |ring_vec;

  always_comb begin
    ring_src = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--)
      if (ring_vec[i])
        ring_src = IDX_W'(i);
  end

endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - directed and randomized checks of alarm_bank against a minute-of-day model
module tb_alarm_bank;

  logic        clk;
  logic        rst;
  logic [10:0] time_in;
  logic [10:0] time_set_in;
  logic [1:0]  set_idx;
  logic        set_time;
  logic [3:0]  en_in;
  logic        snooze;
  logic        end_ring;
  logic        ring;
  logic [3:0]  ring_vec;
  logic [1:0]  ring_src;
  logic        set_err;

  int errors = 0;
  int checks = 0;

  alarm_bank #(.N_ALARMS(4), .SNOOZE_MIN(5), .TIMEOUT_MIN(10)) dut (
    .clk(clk), .rst(rst), .time_in(time_in), .time_set_in(time_set_in),
    .set_idx(set_idx), .set_time(set_time), .en_in(en_in), .snooze(snooze),
    .end_ring(end_ring), .ring(ring), .ring_vec(ring_vec), .ring_src(ring_src),
    .set_err(set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: times as minutes of day, states 0=idle 1=ringing 2=snoozed
  int          m_alarm[4];
  int          m_st[4];
  int          m_snz[4];
  int          m_tmo[4];
  logic [10:0] m_prev;
  logic        m_err;

  function automatic int to_min(input logic [10:0] t);
    return int'(t[10:6]) * 60 + int'(t[5:0]);
  endfunction

  function automatic logic [10:0] hm(input int h, input int m);
    return {5'(h), 6'(m)};
  endfunction

  function automatic logic [3:0] exp_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (m_st[i] == 1);
    return v;
  endfunction

  function automatic logic [1:0] exp_src();
    logic [1:0] s;
    s = 2'd0;
    for (int i = 3; i >= 0; i--) if (m_st[i] == 1) s = 2'(i);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_alarm[i] = 0; m_st[i] = 0; m_snz[i] = 0; m_tmo[i] = 0;
    end
    m_prev = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    bit tick, valid, sel;
    int now;
    tick  = (time_in != m_prev);
    valid = (time_set_in[10:6] <= 23) && (time_set_in[5:0] <= 59);
    now   = to_min(time_in);
    for (int i = 0; i < 4; i++) begin
      sel = set_time && valid && (int'(set_idx) == i);
      if (sel) m_alarm[i] = to_min(time_set_in);
      if (!en_in[i] || sel || end_ring) begin
        m_st[i] = 0; m_tmo[i] = 0;
      end else if (m_st[i] == 1 && snooze) begin
        m_st[i] = 2; m_snz[i] = (now + 5) % 1440;
      end else if (tick && m_st[i] == 0 && now == m_alarm[i]) begin
        m_st[i] = 1; m_tmo[i] = 0;
      end else if (tick && m_st[i] == 2 && now == m_snz[i]) begin
        m_st[i] = 1; m_tmo[i] = 0;
      end else if (tick && m_st[i] == 1) begin
        m_tmo[i]++;
        if (m_tmo[i] >= 10) begin m_st[i] = 0; m_tmo[i] = 0; end
      end
    end
    m_err  = set_time && !valid;
    m_prev = time_in;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alarm(input int idx, input int h, input int m);
    set_idx = 2'(idx); time_set_in = hm(h, m); set_time = 1'b1;
    cycle();
    set_time = 1'b0;
  endtask

  task automatic goto_time(input int h, input int m);
    time_in = hm(h, m);
    cycle();
  endtask

  task automatic pulse_end();
    end_ring = 1'b1; cycle(); end_ring = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL reset_ring: got %b expected 0", ring); end
    checks++; if (ring_vec !== 4'b0000) begin errors++; $display("FAIL reset_vec: got %b expected 0000", ring_vec); end
    checks++; if (ring_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d expected 0", ring_src); end
    checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL reset_set_err: got %b expected 0", set_err); end
  endtask

  task automatic test_single_ring();
    en_in = 4'b0001;
    set_alarm(0, 8, 30);
    goto_time(8, 29);
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL single_pre: got %b expected 0", ring); end
    time_in = hm(8, 30);
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", ring); end
    cycle();
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL single_ring: got %b expected 1", ring); end
    checks++; if (ring_vec !== 4'b0001) begin errors++; $display("FAIL single_vec: got %b expected 0001", ring_vec); end
    checks++; if (ring_src !== 2'd0) begin errors++; $display("FAIL single_src: got %0d expected 0", ring_src); end
    pulse_end();
  endtask

  task automatic test_multi_ring();
    en_in = 4'b0110;
    set_alarm(1, 8, 30);
    set_alarm(2, 8, 30);
    goto_time(8, 29);
    goto_time(8, 30);
    checks++; if (ring_vec !== 4'b0110) begin errors++; $display("FAIL multi_vec: got %b expected 0110", ring_vec); end
    checks++; if (ring_src !== 2'd1) begin errors++; $display("FAIL multi_src: got %0d expected 1", ring_src); end
    pulse_end();
    checks++; if (ring_vec !== 4'b0000) begin errors++; $display("FAIL multi_end: got %b expected 0000", ring_vec); end
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++; if (ring !== 1'b0) begin errors++; $display("FAIL multi_noretrig: got %b expected 0", ring); end
    end
  endtask

  task automatic test_snooze();
    int seq[4] = '{23 * 60 + 59, 0, 1, 2};
    en_in = 4'b0001;
    set_alarm(0, 23, 58);
    goto_time(23, 57);
    goto_time(23, 58);
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL snooze_first: got %b expected 1", ring); end
    snooze = 1'b1; cycle(); snooze = 1'b0;
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL snooze_quiet: got %b expected 0", ring); end
    for (int k = 0; k < 4; k++) begin
      goto_time(seq[k] / 60, seq[k] % 60);
      checks++; if (ring !== 1'b0) begin errors++; $display("FAIL snooze_wait: got %b expected 0 at min %0d", ring, seq[k]); end
    end
    goto_time(0, 3);
    checks++; if (ring_vec !== 4'b0001) begin errors++; $display("FAIL snooze_again: got %b expected 0001", ring_vec); end
    pulse_end();
  endtask

  task automatic test_timeout();
    en_in = 4'b1000;
    set_alarm(3, 15, 45);
    goto_time(15, 44);
    goto_time(15, 45);
    checks++; if (ring_vec !== 4'b1000) begin errors++; $display("FAIL tmo_vec: got %b expected 1000", ring_vec); end
    checks++; if (ring_src !== 2'd3) begin errors++; $display("FAIL tmo_src: got %0d expected 3", ring_src); end
    for (int m = 46; m <= 54; m++) begin
      goto_time(15, m);
      checks++; if (ring !== 1'b1) begin errors++; $display("FAIL tmo_hold: got %b expected 1 at 15:%0d", ring, m); end
    end
    goto_time(15, 55);
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", ring); end
  endtask

  task automatic test_set_err();
    en_in = 4'b0011;
    set_alarm(0, 6, 0);
    checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL set_ok_err: got %b expected 0", set_err); end
    set_idx = 2'd0; time_set_in = hm(24, 10); set_time = 1'b1; cycle(); set_time = 1'b0;
    checks++; if (set_err !== 1'b1) begin errors++; $display("FAIL set_err_hour: got %b expected 1", set_err); end
    cycle();
    checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL set_err_pulse: got %b expected 0", set_err); end
    set_idx = 2'd0; time_set_in = hm(7, 60); set_time = 1'b1; cycle(); set_time = 1'b0;
    checks++; if (set_err !== 1'b1) begin errors++; $display("FAIL set_err_min: got %b expected 1", set_err); end
    set_alarm(1, 6, 0);
    goto_time(5, 59);
    goto_time(6, 0);
    checks++; if (ring_vec !== 4'b0011) begin errors++; $display("FAIL set_unchanged: got %b expected 0011", ring_vec); end
    set_alarm(0, 7, 0);
    checks++; if (ring_vec !== 4'b0010) begin errors++; $display("FAIL set_on_ring: got %b expected 0010", ring_vec); end
    checks++; if (ring_src !== 2'd1) begin errors++; $display("FAIL set_on_ring_src: got %0d expected 1", ring_src); end
    pulse_end();
  endtask

  task automatic test_reset_mid();
    en_in = 4'b0001;
    set_alarm(0, 10, 0);
    goto_time(9, 59);
    goto_time(10, 0);
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", ring); end
    #3 rst = 1'b0;
    #1;
    checks++; if ({ring, ring_vec, ring_src, set_err} !== 8'd0) begin errors++; $display("FAIL rstmid_ring: got %b expected 00000000", {ring, ring_vec, ring_src, set_err}); end
    #2 rst = 1'b1;
    model_reset();
    cycle();
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %b expected 0", ring); end
    set_alarm(0, 11, 0);
    goto_time(10, 59);
    goto_time(11, 0);
    snooze = 1'b1; cycle(); snooze = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++; if ({ring, ring_vec, ring_src, set_err} !== 8'd0) begin errors++; $display("FAIL rstmid_snz: got %b expected 00000000", {ring, ring_vec, ring_src, set_err}); end
    #2 rst = 1'b1;
    model_reset();
    goto_time(11, 5);
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL rstmid_snz_target: got %b expected 0", ring); end
    en_in = 4'b1111;
    goto_time(23, 59);
    goto_time(0, 0);
    checks++; if (ring_vec !== 4'b1111) begin errors++; $display("FAIL rstmid_zero_alarm: got %b expected 1111", ring_vec); end
    checks++; if (ring_src !== 2'd0) begin errors++; $display("FAIL rstmid_zero_src: got %0d expected 0", ring_src); end
    pulse_end();
  endtask

  task automatic test_random();
    int now, t;
    en_in = 4'b1111;
    now = to_min(time_in);
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) now = (now + 1) % 1440;
      else if (r < 33) now = $urandom_range(0, 1439);
      time_in = hm(now / 60, now % 60);
      set_time = ($urandom_range(0, 14) == 0);
      set_idx  = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r == 0) time_set_in = hm($urandom_range(24, 31), $urandom_range(0, 63));
      else if (r == 1) time_set_in = hm($urandom_range(0, 23), $urandom_range(60, 63));
      else begin
        t = (now + $urandom_range(0, 3)) % 1440;
        time_set_in = hm(t / 60, t % 60);
      end
      if ($urandom_range(0, 39) == 0) en_in = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      snooze   = ($urandom_range(0, 14) == 0);
      end_ring = ($urandom_range(0, 29) == 0);
      cycle();
      checks++; if (ring_vec !== exp_vec()) begin errors++; $display("FAIL rand_vec: got %b expected %b at iter %0d", ring_vec, exp_vec(), n); end
      checks++; if (ring !== (|exp_vec())) begin errors++; $display("FAIL rand_ring: got %b expected %b at iter %0d", ring, |exp_vec(), n); end
      checks++; if (ring_src !== exp_src()) begin errors++; $display("FAIL rand_src: got %0d expected %0d at iter %0d", ring_src, exp_src(), n); end
      checks++; if (set_err !== m_err) begin errors++; $display("FAIL rand_set_err: got %b expected %b at iter %0d", set_err, m_err, n); end
    end
    set_time = 1'b0; snooze = 1'b0; end_ring = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    time_in = '0; time_set_in = '0; set_idx = '0; set_time = 1'b0;
    en_in = '0; snooze = 1'b0; end_ring = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    test_single_ring();
    test_multi_ring();
    test_snooze();
    test_timeout();
    test_set_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
